// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with write-back select.
// Captures the MEM-stage results each clock, picks the register-file write
// data (ALU / load data / link address), gates the write enable against
// bubbles and the zero register, and counts retired instructions.
// Optional feature macro: MEM_WB_RETIRE_CNT_EN
//   defined   -> retire_count is a wrapping counter of retired instructions
//   undefined -> retire_count is tied to 0 (port still present)
// All state uses a synchronous active-low reset (reset_n).
module mem_wb_stage #(
  parameter int          CNT_W    = 32,
  parameter logic [4:0]  ZERO_REG = 5'd0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             EX_MEM_valid,
  input  logic [31:0]      EX_MEM_alu_out,
  input  logic [31:0]      dm_out,
  input  logic [31:0]      EX_MEM_pc_plus4,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             EX_MEM_RegWrite,
  input  logic [1:0]       EX_MEM_MemtoReg,
  output logic             MEM_WB_valid,
  output logic [4:0]       MEM_WB_rd,
  output logic             MEM_WB_RegWrite,
  output logic [31:0]      MEM_WB_wdata,
  output logic [CNT_W-1:0] retire_count
);

  // Write-back mux; the reserved code falls back to the ALU result so the
  // write data is always a defined value.
  function automatic logic [31:0] wb_select(
    input logic [1:0]  sel,
    input logic [31:0] alu,
    input logic [31:0] mem,
    input logic [31:0] link
  );
    logic [31:0] res;
    case (sel)
      2'b00:   res = alu;
      2'b01:   res = mem;
      2'b10:   res = link;
      2'b11:   res = alu;
      default: res = alu;
    endcase
    return res;
  endfunction

  logic        w_load;
  logic        w_regwrite;
  logic [31:0] w_wdata;

  logic        r_valid;
  logic [4:0]  r_rd;
  logic        r_regwrite;
  logic [31:0] r_wdata;

  // Next-cycle write-back data, gated write enable and the "normal load" condition.
  always_comb begin
    w_wdata    = 32'd0;
    w_regwrite = 1'b0;
    w_load     = 1'b0;
    w_wdata    = wb_select(EX_MEM_MemtoReg, EX_MEM_alu_out, dm_out, EX_MEM_pc_plus4);
    if (EX_MEM_valid && EX_MEM_RegWrite && (EX_MEM_rd != ZERO_REG)) begin
      w_regwrite = 1'b1;
    end else begin
      w_regwrite = 1'b0;
    end
    if (!flush && !stall) begin
      w_load = 1'b1;
    end else begin
      w_load = 1'b0;
    end
  end

  // Pipeline register: reset > flush (bubble) > stall (hold) > load.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_rd       <= 5'd0;
      r_regwrite <= 1'b0;
      r_wdata    <= 32'd0;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_rd       <= 5'd0;
      r_regwrite <= 1'b0;
      r_wdata    <= 32'd0;
    end else if (stall) begin
      r_valid    <= r_valid;
      r_rd       <= r_rd;
      r_regwrite <= r_regwrite;
      r_wdata    <= r_wdata;
    end else begin
      // A bubble still captures rd/wdata; valid and the enable stay low.
      r_valid    <= EX_MEM_valid;
      r_rd       <= EX_MEM_rd;
      r_regwrite <= w_regwrite;
      r_wdata    <= w_wdata;
    end
  end

  assign MEM_WB_valid    = r_valid;
  assign MEM_WB_rd       = r_rd;
  assign MEM_WB_RegWrite = r_regwrite;
  assign MEM_WB_wdata    = r_wdata;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retire;

  // Retired-instruction counter; wraps silently at all-ones.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_retire <= {CNT_W{1'b0}};
    end else if (w_load && EX_MEM_valid) begin
      r_retire <= r_retire + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_retire <= r_retire;
    end
  end

  assign retire_count = r_retire;
`else
  assign retire_count = {CNT_W{1'b0}};
`endif

endmodule
